conv_sequencer: RTL

Control sequencer for the D×D PE mesh (the convolutional unit). On a start handshake it latches a layer configuration, then for each output tile it clears the PE accumulators, steps a K×K kernel window and drives kernel- and neuron-buffer read addresses. It then drains the partial sums across the mesh columns and flags each finished tile. It drives the mesh's `columnControl`, `rowControl` and `commonControl` buses directly and sits between the layer-level scheduler and the mesh/buffers.

---
 rtl/conv_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/conv_sequencer.sv
// Control sequencer for the DxD PE mesh: per output tile it clears accumulators, walks a KxK
// kernel window over the kernel/neuron buffers, drains the partial sums and flags the tile.
module conv_sequencer #(
  parameter int unsigned depth = 2,
  parameter int unsigned D     = 1 << depth,
  parameter int unsigned A     = 7
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  output logic                 ready,
  input  logic                 abort,
  input  logic [2:0]           cfgK,
  input  logic [A-1:0]         cfgStride,
  input  logic [A-1:0]         cfgTiles,
  input  logic [D-1:0]         cfgRows,
  output logic [A-1:0]         kAddr,
  output logic [A-1:0]         nAddr,
  output logic                 rdEn,
  output logic [D*8-1:0]       columnControl,
  output logic [D-1:0]         rowControl,
  output logic [3*depth+2*A:0] commonControl,
  output logic                 outValid,
  output logic                 done
);

  typedef enum logic [2:0] {StIdle, StLoad, StClear, StMac, StWait, StDrain, StFin} state_e;

  localparam logic [depth-1:0] DLast = {depth{1'b1}};

  state_e           state_q;
  logic [2:0]       km1_q, kr_q, kc_q;
  logic [A-1:0]     stride_q, tiles_q, tile_q, tile_base_q, row_base_q;
  logic [D-1:0]     rows_q, sum_q;
  logic [depth-1:0] d_q;
  logic             mac_en_q, clear_q, acc_en_q;
  logic [A-1:0]     tile_inc;

  assign ready    = (state_q == StIdle);
  assign tile_inc = tile_q + 1'b1;

  assign commonControl = {acc_en_q, {(A-3){1'b0}}, kr_q, {(A-3){1'b0}}, kc_q,
                          tile_q[3*depth-1:0]};

  always_comb begin
    columnControl = '0;
    for (int c = 0; c < D; c++) begin
      columnControl[8*c +: 3] = {sum_q[c], clear_q, mac_en_q};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      km1_q       <= '0;
      stride_q    <= '0;
      tiles_q     <= '0;
      rows_q      <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      tile_q      <= '0;
      tile_base_q <= '0;
      row_base_q  <= '0;
      d_q         <= '0;
      sum_q       <= '0;
      mac_en_q    <= 1'b0;
      clear_q     <= 1'b0;
      acc_en_q    <= 1'b0;
      kAddr       <= '0;
      nAddr       <= '0;
      rdEn        <= 1'b0;
      rowControl  <= '0;
      outValid    <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      // Abort silences every control line at once, including the delayed macEn/outValid.
      state_q     <= StIdle;
      kr_q        <= '0;
      kc_q        <= '0;
      tile_q      <= '0;
      tile_base_q <= '0;
      row_base_q  <= '0;
      d_q         <= '0;
      sum_q       <= '0;
      mac_en_q    <= 1'b0;
      clear_q     <= 1'b0;
      acc_en_q    <= 1'b0;
      kAddr       <= '0;
      nAddr       <= '0;
      rdEn        <= 1'b0;
      rowControl  <= '0;
      outValid    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done     <= 1'b0;
      clear_q  <= 1'b0;
      mac_en_q <= rdEn;
      outValid <= sum_q[D-1];
      unique case (state_q)
        StIdle: begin
          if (start) begin
            km1_q    <= (cfgK == 3'd0) ? 3'd0 : cfgK - 3'd1;
            stride_q <= cfgStride;
            tiles_q  <= cfgTiles;
            rows_q   <= cfgRows;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          tile_q      <= '0;
          tile_base_q <= '0;
          if (tiles_q == '0) begin
            state_q <= StFin;
            done    <= 1'b1;
          end else begin
            state_q    <= StClear;
            clear_q    <= 1'b1;
            kr_q       <= '0;
            kc_q       <= '0;
            rowControl <= rows_q;
          end
        end
        StClear: begin
          state_q    <= StMac;
          rdEn       <= 1'b1;
          acc_en_q   <= 1'b1;
          kAddr      <= '0;
          nAddr      <= tile_base_q;
          row_base_q <= tile_base_q;
        end
        StMac: begin
          if (kc_q == km1_q) begin
            if (kr_q == km1_q) begin
              state_q <= StWait;
              rdEn    <= 1'b0;
            end else begin
              // Next kernel row: neuron address jumps to the start of the next buffer row.
              kc_q       <= '0;
              kr_q       <= kr_q + 3'd1;
              kAddr      <= kAddr + 1'b1;
              row_base_q <= row_base_q + stride_q;
              nAddr      <= row_base_q + stride_q;
            end
          end else begin
            kc_q  <= kc_q + 3'd1;
            kAddr <= kAddr + 1'b1;
            nAddr <= nAddr + 1'b1;
          end
        end
        StWait: begin
          state_q  <= StDrain;
          acc_en_q <= 1'b0;
          d_q      <= '0;
          sum_q    <= {{(D-1){1'b0}}, 1'b1};
        end
        StDrain: begin
          if (d_q == DLast) begin
            sum_q       <= '0;
            tile_q      <= tile_inc;
            tile_base_q <= tile_base_q + 1'b1;
            if (tile_inc < tiles_q) begin
              state_q <= StClear;
              clear_q <= 1'b1;
              kr_q    <= '0;
              kc_q    <= '0;
            end else begin
              state_q    <= StFin;
              done       <= 1'b1;
              rowControl <= '0;
            end
          end else begin
            d_q   <= d_q + 1'b1;
            sum_q <= sum_q << 1;
          end
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
